id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the pipelined 16-bit CPU, directly downstream of the fetch stage (PC register plus instruction memory). It accepts one fetched instruction per cycle, decodes the opcode, and reads a 16x16 register file that has a write port driven by writeback. It produces the registered ID/EX pipeline bundle and tells fetch to hold on a load-use hazard. It also kills work on branch flush and latches a sticky halt once HLT is decoded.

## Interface
- No parameters; widths fixed (16-bit data, 4-bit register index).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents a valid instruction
- if_instr  in  16  fetched instruction
- if_pc_next  in  16  address of the following instruction, from fetch
- flush  in  1  branch taken in EX; kill instruction in ID
- wb_we, wb_rd[3:0], wb_data[15:0]  in  register-file write port
- id_stall  out  1  combinational; fetch holds PC and if_instr this cycle
- ex_valid  out  1  EX bundle holds a real instruction
- ex_opcode  out  4; ex_rd  out  4; ex_rs_idx, ex_rt_idx  out  4 each
- ex_rs_data, ex_rt_data  out  16  operand values
- ex_imm  out  16  extended immediate
- ex_ccc  out  3  branch condition
- ex_reg_we, ex_mem_re, ex_mem_we, ex_hlt  out  1 each  control
- ex_pc_next  out  16  if_pc_next carried forward
- halted  out  1  sticky; set when HLT enters EX

## Operation
- Fields: op=[15:12], a=[11:8], b=[7:4], c=[3:0].
- ALU ops 0000–0011 and 0111: rd=a, rs=b, rt=c, reg_we.
- Shifts/rotate 0100–0110: rd=a, rs=b, imm=zext(c), no rt.
- LW 1000: rd=a, rs=b, imm=sext(c)<<1, reg_we, mem_re.
- SW 1001: rs=b, rt=a (store data), imm=sext(c)<<1, mem_we.
- LHB 1010 / LLB 1011: rd=a, rs=a (old value), imm=zext([7:0]), reg_we.
- B 1100: ccc=[11:9], imm=sext([8:0])<<1.
- BR 1101: ccc=[11:9], rs=b.
- PCS 1110: rd=a, reg_we.
- HLT 1111: hlt.
- Unused source indices are driven as 0.
- Register file: 16 entries. R0 reads 0 and writes to R0 are ignored. Write on rising edge when wb_we.
- Bypass: when wb_we, wb_rd!=0, and wb_rd equals a source index in the same cycle, the operand takes wb_data.
- Load-use: id_stall=1 when if_valid, ex_valid, ex_mem_re, ex_rd!=0, and ex_rd matches a used source of if_instr. On that edge the EX bundle loads a bubble (ex_valid=0, all control 0).
- Flush: the EX bundle loads a bubble and id_stall is forced to 0. Flush has priority over stall.
- Halt: when the EX bundle loads HLT, halted goes to 1. While halted=1, every EX load is a bubble and id_stall=0. Only reset clears halted.
- if_valid=0 loads a bubble.

## Timing
- Reset (async): all ex_* = 0, halted=0, register file cleared to 0.
- Latency is 1 cycle, if_instr to EX bundle, on the next rising edge.
- id_stall is combinational in the same cycle; the stall lasts exactly 1 cycle per load-use hazard.
- Simultaneous wb write and read of the same register returns the new value.
- A reset asserted mid-stall clears everything; the first post-reset instruction proceeds without a stall.

## Test plan
- Reset: assert rst_n=0 mid-run -> all ex_* = 0, halted=0, id_stall=0 immediately, without waiting for a clock.
- Write then ADD: write R1=0x0005 and R2=0x0007 via wb, then issue 0x0312 (ADD R3,R1,R2) -> next edge ex_valid=1, ex_rd=3, ex_rs_data=0x0005, ex_rt_data=0x0007, ex_reg_we=1.
- Bypass and R0: wb writes R4=0xBEEF in the same cycle as 0x0540 (ADD R5,R4,R0) -> ex_rs_data=0xBEEF, ex_rt_data=0x0000.
- Load-use, then flush priority:
  - Issue LW R6 (0x8620), then 0x0761 (ADD R7,R6,R1) -> id_stall=1 for one cycle, one bubble, then ADD appears.
  - Repeat with flush=1 during the stall cycle -> id_stall=0, bubble loaded.
- Immediates: B with imm9=0x1FF -> ex_imm=0xFFFE; LLB R2,0x80 (0xB280) -> ex_imm=0x0080, ex_rs_idx=2.
- Halt: issue 0xF000 -> ex_hlt=1 and halted=1 after the edge; following valid instructions produce only bubbles until reset.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: field decode, 16x16 register file with write-through
// bypass, load-use stall detection, flush/halt bubble insertion and the ID/EX register.
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  input  logic [15:0] if_pc_next,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [3:0]  wb_rd,
  input  logic [15:0] wb_data,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [3:0]  ex_opcode,
  output logic [3:0]  ex_rd,
  output logic [3:0]  ex_rs_idx,
  output logic [3:0]  ex_rt_idx,
  output logic [15:0] ex_rs_data,
  output logic [15:0] ex_rt_data,
  output logic [15:0] ex_imm,
  output logic [2:0]  ex_ccc,
  output logic        ex_reg_we,
  output logic        ex_mem_re,
  output logic        ex_mem_we,
  output logic        ex_hlt,
  output logic [15:0] ex_pc_next,
  output logic        halted
);

  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LHB = 4'hA;
  localparam logic [3:0] OP_LLB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [15:0] rf [16];

  logic [3:0]  op, fa, fb, fc;
  logic [3:0]  dec_rd, dec_rs, dec_rt;
  logic [15:0] dec_imm;
  logic [2:0]  dec_ccc;
  logic        dec_reg_we, dec_mem_re, dec_mem_we, dec_hlt;
  logic [15:0] rs_data, rt_data;
  logic        load_use, bubble;

  assign op = if_instr[15:12];
  assign fa = if_instr[11:8];
  assign fb = if_instr[7:4];
  assign fc = if_instr[3:0];

  always_comb begin
    dec_rd     = 4'd0;
    dec_rs     = 4'd0;
    dec_rt     = 4'd0;
    dec_imm    = 16'd0;
    dec_ccc    = 3'd0;
    dec_reg_we = 1'b0;
    dec_mem_re = 1'b0;
    dec_mem_we = 1'b0;
    dec_hlt    = 1'b0;
    case (op)
      OP_SLL, OP_SRA, OP_ROR: begin
        dec_rd     = fa;
        dec_rs     = fb;
        dec_imm    = {12'd0, fc};
        dec_reg_we = 1'b1;
      end
      OP_LW: begin
        dec_rd     = fa;
        dec_rs     = fb;
        dec_imm    = {{11{fc[3]}}, fc, 1'b0};
        dec_reg_we = 1'b1;
        dec_mem_re = 1'b1;
      end
      OP_SW: begin
        dec_rs     = fb;
        dec_rt     = fa;
        dec_imm    = {{11{fc[3]}}, fc, 1'b0};
        dec_mem_we = 1'b1;
      end
      // Byte loads merge into the destination, so the old value is read through rs.
      OP_LHB, OP_LLB: begin
        dec_rd     = fa;
        dec_rs     = fa;
        dec_imm    = {8'd0, if_instr[7:0]};
        dec_reg_we = 1'b1;
      end
      OP_B: begin
        dec_ccc = if_instr[11:9];
        dec_imm = {{6{if_instr[8]}}, if_instr[8:0], 1'b0};
      end
      OP_BR: begin
        dec_ccc = if_instr[11:9];
        dec_rs  = fb;
      end
      OP_PCS: begin
        dec_rd     = fa;
        dec_reg_we = 1'b1;
      end
      OP_HLT: begin
        dec_hlt = 1'b1;
      end
      default: begin
        dec_rd     = fa;
        dec_rs     = fb;
        dec_rt     = fc;
        dec_reg_we = 1'b1;
      end
    endcase
  end

  // A same-cycle writeback is forwarded so the read sees the value being written.
  always_comb begin
    rs_data = 16'd0;
    rt_data = 16'd0;
    if (dec_rs != 4'd0)
      rs_data = (wb_we && wb_rd == dec_rs) ? wb_data : rf[dec_rs];
    if (dec_rt != 4'd0)
      rt_data = (wb_we && wb_rd == dec_rt) ? wb_data : rf[dec_rt];
  end

  // Unused source indices decode to 0 and ex_rd must be nonzero, so no use flags are needed.
  assign load_use = ex_valid && ex_mem_re && (ex_rd != 4'd0) &&
                    ((ex_rd == dec_rs) || (ex_rd == dec_rt));
  assign id_stall = if_valid && load_use && !flush && !halted;
  assign bubble   = !if_valid || flush || halted || id_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'd0;
    end else if (wb_we && wb_rd != 4'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_opcode  <= 4'd0;
      ex_rd      <= 4'd0;
      ex_rs_idx  <= 4'd0;
      ex_rt_idx  <= 4'd0;
      ex_rs_data <= 16'd0;
      ex_rt_data <= 16'd0;
      ex_imm     <= 16'd0;
      ex_ccc     <= 3'd0;
      ex_reg_we  <= 1'b0;
      ex_mem_re  <= 1'b0;
      ex_mem_we  <= 1'b0;
      ex_hlt     <= 1'b0;
      ex_pc_next <= 16'd0;
    end else if (bubble) begin
      ex_valid   <= 1'b0;
      ex_opcode  <= 4'd0;
      ex_rd      <= 4'd0;
      ex_rs_idx  <= 4'd0;
      ex_rt_idx  <= 4'd0;
      ex_rs_data <= 16'd0;
      ex_rt_data <= 16'd0;
      ex_imm     <= 16'd0;
      ex_ccc     <= 3'd0;
      ex_reg_we  <= 1'b0;
      ex_mem_re  <= 1'b0;
      ex_mem_we  <= 1'b0;
      ex_hlt     <= 1'b0;
      ex_pc_next <= 16'd0;
    end else begin
      ex_valid   <= 1'b1;
      ex_opcode  <= op;
      ex_rd      <= dec_rd;
      ex_rs_idx  <= dec_rs;
      ex_rt_idx  <= dec_rt;
      ex_rs_data <= rs_data;
      ex_rt_data <= rt_data;
      ex_imm     <= dec_imm;
      ex_ccc     <= dec_ccc;
      ex_reg_we  <= dec_reg_we;
      ex_mem_re  <= dec_mem_re;
      ex_mem_we  <= dec_mem_we;
      ex_hlt     <= dec_hlt;
      ex_pc_next <= if_pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      halted <= 1'b0;
    else if (!bubble && dec_hlt)
      halted <= 1'b1;
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed vectors push expected EX bundles, a monitor
// pops and compares one bundle after each clock edge that follows an issued vector.
module tb_id_stage;

  typedef struct packed {
    logic        valid;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs_idx;
    logic [3:0]  rt_idx;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
    logic [2:0]  ccc;
    logic [3:0]  ctl;
    logic [15:0] pc_next;
    logic        halted;
  } bundle_t;

  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_WE   = 4'b1000;
  localparam logic [3:0] C_LW   = 4'b1100;
  localparam logic [3:0] C_SW   = 4'b0010;
  localparam logic [3:0] C_HLT  = 4'b0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_next;
  logic        flush;
  logic        wb_we;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        id_stall;
  logic        ex_valid;
  logic [3:0]  ex_opcode, ex_rd, ex_rs_idx, ex_rt_idx;
  logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_next;
  logic [2:0]  ex_ccc;
  logic        ex_reg_we, ex_mem_re, ex_mem_we, ex_hlt;
  logic        halted;

  int checks = 0;
  int passed = 0;
  bundle_t exp_q[$];

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc_next(if_pc_next), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_rs_idx(ex_rs_idx),
    .ex_rt_idx(ex_rt_idx), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_ccc(ex_ccc), .ex_reg_we(ex_reg_we),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_hlt(ex_hlt),
    .ex_pc_next(ex_pc_next), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
  endtask

  function automatic bundle_t inst(input logic [3:0] op, rd, rs, rt,
                                   input logic [15:0] rsd, rtd, imm,
                                   input logic [2:0] ccc, input logic [3:0] ctl,
                                   input logic [15:0] pc, input logic h);
    bundle_t b;
    b = '{valid: 1'b1, opcode: op, rd: rd, rs_idx: rs, rt_idx: rt, rs_data: rsd,
          rt_data: rtd, imm: imm, ccc: ccc, ctl: ctl, pc_next: pc, halted: h};
    return b;
  endfunction

  function automatic bundle_t bubble(input logic h);
    bundle_t b;
    b = '0;
    b.halted = h;
    return b;
  endfunction

  task automatic checkOutput(input bundle_t e);
    checkField("ex_valid", {15'd0, ex_valid}, {15'd0, e.valid});
    checkField("ex_ctl", {12'd0, ex_reg_we, ex_mem_re, ex_mem_we, ex_hlt}, {12'd0, e.ctl});
    checkField("halted", {15'd0, halted}, {15'd0, e.halted});
    if (e.valid) begin
      checkField("ex_opcode", {12'd0, ex_opcode}, {12'd0, e.opcode});
      checkField("ex_rd", {12'd0, ex_rd}, {12'd0, e.rd});
      checkField("ex_rs_idx", {12'd0, ex_rs_idx}, {12'd0, e.rs_idx});
      checkField("ex_rt_idx", {12'd0, ex_rt_idx}, {12'd0, e.rt_idx});
      checkField("ex_rs_data", ex_rs_data, e.rs_data);
      checkField("ex_rt_data", ex_rt_data, e.rt_data);
      checkField("ex_imm", ex_imm, e.imm);
      checkField("ex_ccc", {13'd0, ex_ccc}, {13'd0, e.ccc});
      checkField("ex_pc_next", ex_pc_next, e.pc_next);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic [15:0] pc,
                               input logic fl, input logic we, input logic [3:0] wrd,
                               input logic [15:0] wdata, input logic stall_exp,
                               input bundle_t e);
    @(negedge clk);
    if_valid   = v;
    if_instr   = instr;
    if_pc_next = pc;
    flush      = fl;
    wb_we      = we;
    wb_rd      = wrd;
    wb_data    = wdata;
    #1;
    checkField("id_stall", {15'd0, id_stall}, {15'd0, stall_exp});
    exp_q.push_back(e);
  endtask

  task automatic checkResetState(input string tag);
    checkField({tag, "_ex_valid"}, {15'd0, ex_valid}, 16'd0);
    checkField({tag, "_ex_ctl"}, {12'd0, ex_reg_we, ex_mem_re, ex_mem_we, ex_hlt}, 16'd0);
    checkField({tag, "_ex_rd"}, {12'd0, ex_rd}, 16'd0);
    checkField({tag, "_ex_opcode"}, {12'd0, ex_opcode}, 16'd0);
    checkField({tag, "_ex_rs_data"}, ex_rs_data, 16'd0);
    checkField({tag, "_ex_imm"}, ex_imm, 16'd0);
    checkField({tag, "_ex_pc_next"}, ex_pc_next, 16'd0);
    checkField({tag, "_halted"}, {15'd0, halted}, 16'd0);
    checkField({tag, "_id_stall"}, {15'd0, id_stall}, 16'd0);
  endtask

  initial begin
    forever begin
      bundle_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    if_valid = 1'b0; if_instr = 16'h0; if_pc_next = 16'h0;
    flush = 1'b0; wb_we = 1'b0; wb_rd = 4'h0; wb_data = 16'h0;
    #2;
    checkResetState("init");
    @(negedge clk);
    rst_n = 1'b1;

    // register writes, then ADD R3,R1,R2
    applyStimulus(0, 16'h0000, 16'h0000, 0, 1, 4'd1, 16'h0005, 0, bubble(0));
    applyStimulus(0, 16'h0000, 16'h0000, 0, 1, 4'd2, 16'h0007, 0, bubble(0));
    applyStimulus(1, 16'h0312, 16'h0011, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'h0, 4'd3, 4'd1, 4'd2, 16'h0005, 16'h0007, 16'h0000, 3'd0, C_WE, 16'h0011, 0));
    // same-cycle bypass and R0 reads zero; a write to R0 is ignored
    applyStimulus(1, 16'h0540, 16'h0012, 0, 1, 4'd4, 16'hBEEF, 0,
                  inst(4'h0, 4'd5, 4'd4, 4'd0, 16'hBEEF, 16'h0000, 16'h0000, 3'd0, C_WE, 16'h0012, 0));
    applyStimulus(1, 16'h0500, 16'h0013, 0, 1, 4'd0, 16'h1234, 0,
                  inst(4'h0, 4'd5, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, C_WE, 16'h0013, 0));
    applyStimulus(1, 16'h0500, 16'h0014, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'h0, 4'd5, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, C_WE, 16'h0014, 0));

    // load-use on rs: LW R6 then ADD R7,R6,R1; load result written back during the stall
    applyStimulus(1, 16'h8620, 16'h0020, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'h8, 4'd6, 4'd2, 4'd0, 16'h0007, 16'h0000, 16'h0000, 3'd0, C_LW, 16'h0020, 0));
    applyStimulus(1, 16'h0761, 16'h0021, 0, 1, 4'd6, 16'h0042, 1, bubble(0));
    applyStimulus(1, 16'h0761, 16'h0021, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'h0, 4'd7, 4'd6, 4'd1, 16'h0042, 16'h0005, 16'h0000, 3'd0, C_WE, 16'h0021, 0));

    // flush wins over the stall
    applyStimulus(1, 16'h8620, 16'h0030, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'h8, 4'd6, 4'd2, 4'd0, 16'h0007, 16'h0000, 16'h0000, 3'd0, C_LW, 16'h0030, 0));
    applyStimulus(1, 16'h0761, 16'h0031, 1, 0, 4'd0, 16'h0000, 0, bubble(0));

    // load-use on the store-data operand (rt); negative LW offset
    applyStimulus(1, 16'h8A3F, 16'h0040, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'h8, 4'd10, 4'd3, 4'd0, 16'h0000, 16'h0000, 16'hFFFE, 3'd0, C_LW, 16'h0040, 0));
    applyStimulus(1, 16'h9A21, 16'h0041, 0, 0, 4'd0, 16'h0000, 1, bubble(0));
    applyStimulus(1, 16'h9A21, 16'h0041, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'h9, 4'd0, 4'd2, 4'd10, 16'h0007, 16'h0000, 16'h0002, 3'd0, C_SW, 16'h0041, 0));
    applyStimulus(1, 16'h4A35, 16'h0042, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'h4, 4'd10, 4'd3, 4'd0, 16'h0000, 16'h0000, 16'h0005, 3'd0, C_WE, 16'h0042, 0));

    // LW to R0 never causes a stall
    applyStimulus(1, 16'h8010, 16'h0050, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'h8, 4'd0, 4'd1, 4'd0, 16'h0005, 16'h0000, 16'h0000, 3'd0, C_LW, 16'h0050, 0));
    applyStimulus(1, 16'h0300, 16'h0051, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'h0, 4'd3, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, C_WE, 16'h0051, 0));

    // branch and immediate forms
    applyStimulus(1, 16'hCBFF, 16'h0060, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'hC, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'hFFFE, 3'd5, C_NONE, 16'h0060, 0));
    applyStimulus(1, 16'hB280, 16'h0061, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'hB, 4'd2, 4'd2, 4'd0, 16'h0007, 16'h0000, 16'h0080, 3'd0, C_WE, 16'h0061, 0));
    applyStimulus(1, 16'hD410, 16'h0062, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'hD, 4'd0, 4'd1, 4'd0, 16'h0005, 16'h0000, 16'h0000, 3'd2, C_NONE, 16'h0062, 0));
    applyStimulus(1, 16'hE900, 16'h0063, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'hE, 4'd9, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, C_WE, 16'h0063, 0));

    // halt, then everything becomes a bubble and no stall is raised
    applyStimulus(1, 16'hF000, 16'h0100, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'hF, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, C_HLT, 16'h0100, 1));
    applyStimulus(1, 16'h0312, 16'h0101, 0, 0, 4'd0, 16'h0000, 0, bubble(1));
    applyStimulus(1, 16'h8620, 16'h0102, 0, 0, 4'd0, 16'h0000, 0, bubble(1));
    applyStimulus(1, 16'h0761, 16'h0103, 0, 0, 4'd0, 16'h0000, 0, bubble(1));

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetState("rst_async");
    @(negedge clk);
    rst_n = 1'b1;

    // reset during a stall; register file must come back cleared
    applyStimulus(1, 16'h8620, 16'h0200, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'h8, 4'd6, 4'd2, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, C_LW, 16'h0200, 0));
    @(negedge clk);
    if_valid = 1'b1; if_instr = 16'h0761; if_pc_next = 16'h0201;
    flush = 1'b0; wb_we = 1'b0;
    #1;
    checkField("stall_before_reset", {15'd0, id_stall}, 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetState("rst_stall");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 16'h0761, 16'h0201, 0, 0, 4'd0, 16'h0000, 0,
                  inst(4'h0, 4'd7, 4'd6, 4'd1, 16'h0000, 16'h0000, 16'h0000, 3'd0, C_WE, 16'h0201, 0));

    applyStimulus(0, 16'h0000, 16'h0000, 0, 0, 4'd0, 16'h0000, 0, bubble(0));
    repeat (3) @(posedge clk);
    #2;
    checkField("queue_drained", exp_q.size(), 16'd0);
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
